// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage.
// Define DIV_EARLY_EXIT_EN to skip the divider's leading-zero iterations of |a|.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state, next_state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       mul_cnt;
    logic [CW-1:0]    div_cnt;
    logic [WIDTH-1:0] rem, quo, divisor;

    logic             accept, commit;
    logic [WIDTH-1:0] a_mag, b_mag, quo_init;
    logic [CW-1:0]    div_iters;
    logic [2:0]       commit_op;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH:0]   shifted_rem;
    logic             rem_ge;
    logic [WIDTH-1:0] step_rem;
    logic             div_signed, div_zero;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = (state == S_IDLE) && start && !flush;
    assign commit = (next_state == S_DONE) && (state != S_DONE);

    assign a_mag = (op == OP_DIV && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op == OP_DIV && b[WIDTH-1]) ? -b : b;

`ifdef DIV_EARLY_EXIT_EN
    function automatic logic [CW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [CW-1:0] lz;

    // A zero divisor keeps the full iteration count so its latency never depends on a.
    always_comb begin
        lz = count_lz(a_mag);
        if (b == '0) begin
            div_iters = CW'(WIDTH);
            quo_init  = a_mag;
        end else begin
            div_iters = CW'(WIDTH) - lz;
            quo_init  = a_mag << lz;
        end
    end
`else
    assign div_iters = CW'(WIDTH);
    assign quo_init  = a_mag;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_MUL: begin
                            if (MUL_LAT == 1) next_state = S_DONE;
                            else              next_state = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (div_iters == '0) next_state = S_FIX;
                            else                 next_state = S_DIV;
                        end
                        default: next_state = S_DONE;
                    endcase
                end
            end
            S_MUL: begin
                if (flush)               next_state = S_IDLE;
                else if (mul_cnt <= 3'd1) next_state = S_DONE;
            end
            S_DIV: begin
                if (flush)                  next_state = S_IDLE;
                else if (div_cnt == CW'(1)) next_state = S_FIX;
            end
            S_FIX:   next_state = flush ? S_IDLE : S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // One restoring step: the remainder stays below the divisor, so WIDTH+1 bits suffice.
    always_comb begin
        shifted_rem = {rem, quo[WIDTH-1]};
        rem_ge      = shifted_rem >= {1'b0, divisor};
        step_rem    = rem_ge ? WIDTH'(shifted_rem - {1'b0, divisor}) : shifted_rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mul_cnt <= '0;
            div_cnt <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            mul_cnt <= 3'(MUL_LAT - 1);
            div_cnt <= div_iters;
            rem     <= '0;
            quo     <= quo_init;
            divisor <= b_mag;
        end else if (state == S_MUL) begin
            mul_cnt <= mul_cnt - 3'd1;
        end else if (state == S_DIV) begin
            rem     <= step_rem;
            quo     <= {quo[WIDTH-2:0], rem_ge};
            div_cnt <= div_cnt - CW'(1);
        end
    end

    // With MUL_LAT=1 the commit happens on the acceptance edge, so operands come straight from the ports.
    assign commit_op  = (state == S_IDLE) ? op : op_q;
    assign mul_a      = (state == S_IDLE) ? a : a_q;
    assign mul_b      = (state == S_IDLE) ? b : b_q;
    assign mul_signed = (commit_op != OP_MULTU);
    assign ext_a      = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    assign ext_b      = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    assign product    = ext_a * ext_b;

    assign div_signed = (op_q == OP_DIV);
    assign div_zero   = (b_q == '0);
    assign quo_fix    = div_zero ? '1 :
                        (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo : quo;
    assign rem_fix    = div_zero ? a_q :
                        (div_signed && a_q[WIDTH-1]) ? -rem : rem;

    // result and dz live only for the DONE cycle; they clear on every other edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi     <= '0;
            lo     <= '0;
            result <= '0;
            dz     <= 1'b0;
        end else begin
            result <= '0;
            dz     <= 1'b0;
            if (commit) begin
                case (commit_op)
                    OP_MULT, OP_MULTU: begin
                        hi     <= product[2*WIDTH-1:WIDTH];
                        lo     <= product[WIDTH-1:0];
                        result <= product[WIDTH-1:0];
                    end
                    OP_MUL: result <= product[WIDTH-1:0];
                    OP_DIV, OP_DIVU: begin
                        hi     <= rem_fix;
                        lo     <= quo_fix;
                        result <= quo_fix;
                        dz     <= div_zero;
                    end
                    OP_MTHI: begin
                        hi     <= a;
                        result <= lo;
                    end
                    OP_MTLO: begin
                        lo     <= a;
                        result <= a;
                    end
                    default: result <= lo;
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
